if_stage: RTL

Instruction-fetch stage of the 5-stage miniRV pipeline. It produces the `inst` word that the ID-stage control decoder consumes. It owns the PC register and drives the IROM address. It registers the fetched word into the IF/ID pipeline register, applying hazard-unit stalls and the EX-stage redirects implied by the decoder's npc_op (JALR, branch, JAL). It also keeps fetch and flush counters and a sticky misalignment flag for debug.

---
 rtl/if_stage.sv | 98 +++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage of the miniRV 5-stage pipeline: PC register, IROM addressing,
// IF/ID register with stall/redirect handling, plus fetch/flush counters and a misalign flag.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IROM_AW  = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic [IROM_AW-1:0] irom_addr,
  input  logic [31:0]        irom_inst,
  output logic [31:0]        pc_if,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc4,
  output logic [31:0]        if_id_inst,
  output logic               if_id_valid,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        flush_cnt,
  output logic               fetch_misalign
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect outranks stall: a wrong-path fetch must be squashed even if IF/ID is held.
  always_comb begin
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;
    fetch_cnt_d   = fetch_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    misalign_d    = misalign_q;
    if (redirect_valid) begin
      pc_d          = {redirect_target[31:2], 2'b00};
      if_id_pc_d    = 32'd0;
      if_id_pc4_d   = 32'd0;
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
      flush_cnt_d   = flush_cnt_q + 32'd1;
      misalign_d    = misalign_q | (redirect_target[1:0] != 2'b00);
    end else if (!stall) begin
      pc_d          = pc_plus4;
      if_id_pc_d    = pc_q;
      if_id_pc4_d   = pc_plus4;
      if_id_inst_d  = irom_inst;
      if_id_valid_d = 1'b1;
      fetch_cnt_d   = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'd0;
      if_id_pc4_q   <= 32'd0;
      if_id_inst_q  <= NOP_INST;
      if_id_valid_q <= 1'b0;
      fetch_cnt_q   <= 32'd0;
      flush_cnt_q   <= 32'd0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_cnt_q   <= fetch_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      misalign_q    <= misalign_d;
    end
  end

  // IROM address comes straight from the PC flop, never from stall/redirect.
  assign irom_addr      = pc_q[IROM_AW+1:2];
  assign pc_if          = pc_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc4      = if_id_pc4_q;
  assign if_id_inst     = if_id_inst_q;
  assign if_id_valid    = if_id_valid_q;
  assign fetch_cnt      = fetch_cnt_q;
  assign flush_cnt      = flush_cnt_q;
  assign fetch_misalign = misalign_q;

endmodule
